// File: rtl/shutdown_sense_scan.sv
// Scans eight board shutdown lines through an external 8:1 mux and debounces each one.
// A sticky fault flag, the first faulting board and a per-board vector go to the manager.
// Optional SHUTDOWN_SENSE_MASK_EN adds board_mask to discard hits from selected boards.
module shutdown_sense_scan #(
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sense_in,
    input  logic       n_shutdown_rst,
`ifdef SHUTDOWN_SENSE_MASK_EN
    input  logic [7:0] board_mask,
`endif
    output logic [2:0] sense_sel,
    output logic       shutdown_sense,
    output logic [2:0] sense_num,
    output logic [7:0] sense_vec,
    output logic       scan_wrap
);

    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 2;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [0:0] ST_SETTLE = 1'b0;
    localparam logic [0:0] ST_SAMPLE = 1'b1;

    logic             sync1_r;
    logic             sync2_r;
    logic [0:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sample_ok_r;
    logic             end_win_s;
    logic             hit_s;
    logic             board_ok_s;

    // Decode the final sample cycle and whether this board's window is a qualified hit.
    always_comb begin
        end_win_s  = 1'b0;
        hit_s      = 1'b0;
        board_ok_s = 1'b1;
`ifdef SHUTDOWN_SENSE_MASK_EN
        board_ok_s = ~board_mask[sense_sel];
`endif
        if ((state_r == ST_SAMPLE) && (cnt_r == SAMPLE_LAST)) begin
            end_win_s = 1'b1;
            hit_s     = sample_ok_r & sync2_r & board_ok_s;
        end else begin
            end_win_s = 1'b0;
            hit_s     = 1'b0;
        end
    end

    // Two-flop synchronizer for the asynchronous sense pin; keeps running through a clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= sense_in;
            sync2_r <= sync1_r;
        end
    end

    // Scan sequencer, debounce window and sticky fault latch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sense_sel      <= 3'd0;
            shutdown_sense <= 1'b0;
            sense_num      <= 3'd0;
            sense_vec      <= 8'h00;
            scan_wrap      <= 1'b0;
            state_r        <= ST_SETTLE;
            cnt_r          <= '0;
            sample_ok_r    <= 1'b1;
        end else if (!n_shutdown_rst) begin
            // Clear wins over a detection landing in the same cycle.
            sense_sel      <= 3'd0;
            shutdown_sense <= 1'b0;
            sense_num      <= 3'd0;
            sense_vec      <= 8'h00;
            scan_wrap      <= 1'b0;
            state_r        <= ST_SETTLE;
            cnt_r          <= '0;
            sample_ok_r    <= 1'b1;
        end else begin
            scan_wrap <= 1'b0;
            case (state_r)
                ST_SETTLE: begin
                    if (cnt_r == SETTLE_LAST) begin
                        state_r     <= ST_SAMPLE;
                        cnt_r       <= '0;
                        sample_ok_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    sample_ok_r <= sample_ok_r & sync2_r;
                    if (end_win_s) begin
                        if (hit_s) begin
                            sense_vec[sense_sel] <= 1'b1;
                            if (!shutdown_sense) begin
                                shutdown_sense <= 1'b1;
                                sense_num      <= sense_sel;
                            end else begin
                                sense_num <= sense_num;
                            end
                        end else begin
                            sense_vec <= sense_vec;
                        end
                        scan_wrap <= (sense_sel == 3'd7);
                        sense_sel <= sense_sel + 3'd1;
                        state_r   <= ST_SETTLE;
                        cnt_r     <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_SETTLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shutdown_sense_scan.sv
// Directed bench for shutdown_sense_scan (default 4+4 cycle dwell, 64-cycle scan).
module tb_shutdown_sense_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       n_shutdown_rst = 1'b1;
    logic       sense_in;
    logic       use_mux = 1'b0;
    logic       direct = 1'b0;
    logic [7:0] fault_lines = 8'h00;
`ifdef SHUTDOWN_SENSE_MASK_EN
    logic [7:0] board_mask = 8'h00;
`endif
    logic [2:0] sense_sel;
    logic       shutdown_sense;
    logic [2:0] sense_num;
    logic [7:0] sense_vec;
    logic       scan_wrap;

    int total = 0;
    int bad   = 0;

    // External 8:1 mux model, or a directly driven pin for glitch patterns.
    assign sense_in = use_mux ? fault_lines[sense_sel] : direct;

    always #5 clk = ~clk;

    shutdown_sense_scan dut (
        .clk            (clk),
        .rst            (rst),
        .sense_in       (sense_in),
        .n_shutdown_rst (n_shutdown_rst),
`ifdef SHUTDOWN_SENSE_MASK_EN
        .board_mask     (board_mask),
`endif
        .sense_sel      (sense_sel),
        .shutdown_sense (shutdown_sense),
        .sense_num      (sense_num),
        .sense_vec      (sense_vec),
        .scan_wrap      (scan_wrap)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves time just after a posedge with rst high; the next posedge is cycle 1.
    task automatic do_reset();
        rst = 1'b0;
        n_shutdown_rst = 1'b1;
        tick(2);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        use_mux = 1'b0;
        direct  = 1'b0;
        do_reset();
        total++; if (sense_sel !== 3'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", sense_sel); end
        total++; if (shutdown_sense !== 1'b0) begin bad++; $display("FAIL reset_ss got=%b exp=0", shutdown_sense); end
        total++; if (sense_num !== 3'd0) begin bad++; $display("FAIL reset_num got=%0d exp=0", sense_num); end
        total++; if (sense_vec !== 8'h00) begin bad++; $display("FAIL reset_vec got=%h exp=00", sense_vec); end
        total++; if (scan_wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b exp=0", scan_wrap); end
    endtask

    task automatic test_scan_timing();
        int wraps;
        logic [2:0] exp_sel;
        logic exp_wrap;
        use_mux = 1'b0;
        direct  = 1'b0;
        do_reset();
        wraps = 0;
        for (int n = 1; n <= 256; n++) begin
            tick(1);
            exp_sel  = 3'((n / 8) % 8);
            exp_wrap = (n % 64 == 0);
            if (scan_wrap === 1'b1) wraps++;
            total++; if (sense_sel !== exp_sel) begin bad++; $display("FAIL scan_sel cyc=%0d got=%0d exp=%0d", n, sense_sel, exp_sel); end
            total++; if (scan_wrap !== exp_wrap) begin bad++; $display("FAIL scan_wrap cyc=%0d got=%b exp=%b", n, scan_wrap, exp_wrap); end
            total++; if (shutdown_sense !== 1'b0) begin bad++; $display("FAIL scan_ss cyc=%0d got=%b exp=0", n, shutdown_sense); end
        end
        total++; if (wraps != 4) begin bad++; $display("FAIL scan_wrap_count got=%0d exp=4", wraps); end
    endtask

    task automatic test_single_fault();
        use_mux = 1'b1;
        fault_lines = 8'h20;
        do_reset();
        tick(47);
        total++; if (shutdown_sense !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", shutdown_sense); end
        tick(1);
        total++; if (shutdown_sense !== 1'b1) begin bad++; $display("FAIL single_ss got=%b exp=1", shutdown_sense); end
        total++; if (sense_num !== 3'd5) begin bad++; $display("FAIL single_num got=%0d exp=5", sense_num); end
        total++; if (sense_vec !== 8'h20) begin bad++; $display("FAIL single_vec got=%h exp=20", sense_vec); end
        total++; if (sense_sel !== 3'd6) begin bad++; $display("FAIL single_sel got=%0d exp=6", sense_sel); end
        tick(128);
        total++; if ({shutdown_sense, sense_num, sense_vec} !== {1'b1, 3'd5, 8'h20}) begin
            bad++; $display("FAIL single_hold got=%b/%0d/%h exp=1/5/20", shutdown_sense, sense_num, sense_vec);
        end
    endtask

    task automatic test_two_faults();
        use_mux = 1'b1;
        fault_lines = 8'h44;
        do_reset();
        tick(23);
        total++; if (sense_vec !== 8'h00) begin bad++; $display("FAIL two_early got=%h exp=00", sense_vec); end
        tick(1);
        total++; if ({shutdown_sense, sense_num, sense_vec} !== {1'b1, 3'd2, 8'h04}) begin
            bad++; $display("FAIL two_first got=%b/%0d/%h exp=1/2/04", shutdown_sense, sense_num, sense_vec);
        end
        tick(32);
        total++; if (sense_vec !== 8'h44) begin bad++; $display("FAIL two_vec got=%h exp=44", sense_vec); end
        total++; if (sense_num !== 3'd2) begin bad++; $display("FAIL two_num got=%0d exp=2", sense_num); end
    endtask

    // Bit p of a pattern is the synchronized level seen at posedge p; board 3 samples at 29..32.
    task automatic test_glitch();
        logic [63:0] pats [4];
        logic [7:0]  exp_vec [4];
        pats[0] = (64'd1 << 29) | (64'd1 << 31) | (64'd1 << 32);
        pats[1] = (64'd1 << 25) | (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
        pats[2] = (64'd1 << 29) | (64'd1 << 30) | (64'd1 << 31);
        pats[3] = (64'd1 << 29) | (64'd1 << 30) | (64'd1 << 31) | (64'd1 << 32);
        exp_vec[0] = 8'h00;
        exp_vec[1] = 8'h00;
        exp_vec[2] = 8'h00;
        exp_vec[3] = 8'h08;
        use_mux = 1'b0;
        for (int p = 0; p < 4; p++) begin
            direct = 1'b0;
            do_reset();
            for (int c = 1; c <= 40; c++) begin
                direct = pats[p][c + 2];
                tick(1);
            end
            direct = 1'b0;
            total++; if (sense_vec !== exp_vec[p]) begin bad++; $display("FAIL glitch_vec pat=%0d got=%h exp=%h", p, sense_vec, exp_vec[p]); end
            total++; if (shutdown_sense !== (exp_vec[p] != 8'h00)) begin bad++; $display("FAIL glitch_ss pat=%0d got=%b", p, shutdown_sense); end
        end
        total++; if (sense_num !== 3'd3) begin bad++; $display("FAIL glitch_num got=%0d exp=3", sense_num); end
    endtask

    task automatic test_clear_collision();
        use_mux = 1'b1;
        fault_lines = 8'h02;
        do_reset();
        tick(15);
        n_shutdown_rst = 1'b0;
        tick(1);
        n_shutdown_rst = 1'b1;
        total++; if ({shutdown_sense, sense_num, sense_vec, sense_sel, scan_wrap} !== 16'h0000) begin
            bad++; $display("FAIL clear_coll got=%b/%0d/%h/%0d/%b exp=all0", shutdown_sense, sense_num, sense_vec, sense_sel, scan_wrap);
        end
        tick(15);
        total++; if (shutdown_sense !== 1'b0) begin bad++; $display("FAIL clear_early got=%b exp=0", shutdown_sense); end
        tick(1);
        total++; if ({shutdown_sense, sense_num, sense_vec} !== {1'b1, 3'd1, 8'h02}) begin
            bad++; $display("FAIL clear_relatch got=%b/%0d/%h exp=1/1/02", shutdown_sense, sense_num, sense_vec);
        end
        tick(22);
        rst = 1'b0;
        tick(1);
        total++; if ({shutdown_sense, sense_num, sense_vec, sense_sel, scan_wrap} !== 16'h0000) begin
            bad++; $display("FAIL midrst got=%b/%0d/%h/%0d/%b exp=all0", shutdown_sense, sense_num, sense_vec, sense_sel, scan_wrap);
        end
        rst = 1'b1;
        tick(8);
        total++; if (sense_sel !== 3'd1) begin bad++; $display("FAIL midrst_sel got=%0d exp=1", sense_sel); end
        tick(7);
        total++; if (shutdown_sense !== 1'b0) begin bad++; $display("FAIL midrst_early got=%b exp=0", shutdown_sense); end
        tick(1);
        total++; if ({shutdown_sense, sense_num} !== {1'b1, 3'd1}) begin
            bad++; $display("FAIL midrst_relatch got=%b/%0d exp=1/1", shutdown_sense, sense_num);
        end
    endtask

`ifdef SHUTDOWN_SENSE_MASK_EN
    task automatic test_mask();
        logic [2:0] exp_sel;
        use_mux = 1'b1;
        fault_lines = 8'h20;
        board_mask = 8'h20;
        do_reset();
        for (int n = 1; n <= 64; n++) begin
            tick(1);
            exp_sel = 3'((n / 8) % 8);
            total++; if (sense_sel !== exp_sel) begin bad++; $display("FAIL mask_sel cyc=%0d got=%0d exp=%0d", n, sense_sel, exp_sel); end
            total++; if (shutdown_sense !== 1'b0) begin bad++; $display("FAIL mask_ss cyc=%0d got=%b exp=0", n, shutdown_sense); end
        end
        total++; if (sense_vec !== 8'h00) begin bad++; $display("FAIL mask_vec got=%h exp=00", sense_vec); end
        board_mask = 8'h00;
        tick(48);
        total++; if ({shutdown_sense, sense_num, sense_vec} !== {1'b1, 3'd5, 8'h20}) begin
            bad++; $display("FAIL unmask got=%b/%0d/%h exp=1/5/20", shutdown_sense, sense_num, sense_vec);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_scan_timing();
        test_single_fault();
        test_two_faults();
        test_glitch();
        test_clear_collision();
`ifdef SHUTDOWN_SENSE_MASK_EN
        test_mask();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
